// File: rtl/subtractor_nbit_serial.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock, start/done handshake.
// Build option SUB_SATURATE_EN: a final borrow clamps diff to zero (unsigned saturating subtract).
module subtractor_nbit_serial #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_sh_q, a_sh_d;
  logic [N-1:0]     b_sh_q, b_sh_d;
  logic [N-1:0]     res_q, res_d;
  logic [N-1:0]     diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;

  logic             a0, b0, d_bit, br_next, last_bit;
  logic [N-1:0]     res_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
    end
  end

  // One full-subtractor cell applied to the current LSBs
  always_comb begin
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_next = {d_bit, res_q[N-1:1]};
    last_bit = (cnt_q == CNT_W'(N - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          br_d   = 1'b0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_next;
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
`ifdef SUB_SATURATE_EN
          diff_d = br_next ? '0 : res_next;
`else
          diff_d = res_next;
`endif
          borrow_d = br_next;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
